// File: rtl/branch_ckpt_ctrl_if.sv
// Handshake and status bundle between decode/execute and the branch checkpoint controller.
// The controller binds to the slave modport; the checkpoint user binds to master.
interface branch_ckpt_ctrl_if;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic        alloc_ready;
    logic        res_valid;
    logic [2:0]  res_tag;
    logic        res_mispredict;
    logic        res_ready;
    logic        copy_rat;
    logic [2:0]  copy_tag;
    logic        paste_rat;
    logic [2:0]  paste_tag;
    logic        flush;
    logic        release_valid;
    logic [2:0]  release_tag;
    logic        bad_res;
    logic [3:0]  count;

    modport master (
        output alloc_valid, alloc_pc, res_valid, res_tag, res_mispredict,
        input  alloc_ready, res_ready, copy_rat, copy_tag, paste_rat, paste_tag,
               flush, release_valid, release_tag, bad_res, count
    );

    modport slave (
        input  alloc_valid, alloc_pc, res_valid, res_tag, res_mispredict,
        output alloc_ready, res_ready, copy_rat, copy_tag, paste_rat, paste_tag,
               flush, release_valid, release_tag, bad_res, count
    );
endinterface

// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint queue: 8-entry circular buffer of RAT snapshots with mispredict recovery.
// Ready signals are combinational; copy/paste/flush/release/bad_res pulses arrive one cycle later.
module branch_ckpt_ctrl (
    input  logic               clk,
    input  logic               rst,
    branch_ckpt_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, RESTORE, DRAIN} state_t;

    state_t      state, state_nxt;
    logic        drain_cnt;
    logic [7:0]  ent_valid;
    logic [7:0]  ent_resolved;
    logic [31:0] ent_pc [8];
    logic [2:0]  head, tail;
    logic [3:0]  count_q;

    logic        res_acc, tag_ok, res_good, mis_fire, alloc_fire, rel_fire;
    logic [2:0]  keep_dist;
    logic [7:0]  kill;

    assign bus.res_ready   = (state == RUN);
    assign bus.alloc_ready = (state == RUN) && (count_q < 4'd8) &&
                             !(bus.res_valid && bus.res_ready && bus.res_mispredict);
    assign bus.count       = count_q;

    assign res_acc    = bus.res_valid && bus.res_ready;
    assign tag_ok     = ent_valid[bus.res_tag] && !ent_resolved[bus.res_tag];
    assign res_good   = res_acc && tag_ok;
    assign mis_fire   = res_good && bus.res_mispredict;
    assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
    assign rel_fire   = ent_valid[head] && ent_resolved[head];
    // Age of the mispredicted branch relative to head; anything younger gets squashed.
    assign keep_dist  = bus.res_tag - head;

    always_comb begin
        kill = '0;
        for (int i = 0; i < 8; i++) begin
            kill[i] = ((3'(i) - head) > keep_dist);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mis_fire) state_nxt = RESTORE;
            RESTORE: state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_valid    <= '0;
            ent_resolved <= '0;
            for (int i = 0; i < 8; i++) ent_pc[i] <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                ent_valid[tail]    <= 1'b1;
                ent_resolved[tail] <= 1'b0;
                ent_pc[tail]       <= bus.alloc_pc;
                tail               <= tail + 3'd1;
            end
            if (res_good) ent_resolved[bus.res_tag] <= 1'b1;
            if (mis_fire) begin
                ent_valid <= ent_valid & ~kill;
                tail      <= bus.res_tag + 3'd1;
            end
            // Head is never killed, so clearing it after the squash mask is safe.
            if (rel_fire) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 3'd1;
            end
            if (mis_fire) begin
                count_q <= {1'b0, keep_dist} + 4'd1 - {3'b000, rel_fire};
            end else begin
                case ({alloc_fire, rel_fire})
                    2'b10:   count_q <= count_q + 4'd1;
                    2'b01:   count_q <= count_q - 4'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.copy_rat      <= 1'b0;
            bus.copy_tag      <= '0;
            bus.paste_rat     <= 1'b0;
            bus.paste_tag     <= '0;
            bus.flush         <= 1'b0;
            bus.release_valid <= 1'b0;
            bus.release_tag   <= '0;
            bus.bad_res       <= 1'b0;
        end else begin
            bus.copy_rat      <= alloc_fire;
            if (alloc_fire) bus.copy_tag <= tail;
            bus.paste_rat     <= (state_nxt == RESTORE);
            if (mis_fire) bus.paste_tag <= bus.res_tag;
            bus.flush         <= (state_nxt != RUN);
            bus.release_valid <= rel_fire;
            if (rel_fire) bus.release_tag <= head;
            bus.bad_res       <= res_acc && !tag_ok;
        end
    end
endmodule
